// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt controller: bus geometry and register map.
package gpio_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] OFF_DATA_IN  = 5'h00;
    localparam logic [ADDR_W-1:0] OFF_DATA_OUT = 5'h04;
    localparam logic [ADDR_W-1:0] OFF_DIR      = 5'h08;
    localparam logic [ADDR_W-1:0] OFF_IRQ_EN   = 5'h0C;
    localparam logic [ADDR_W-1:0] OFF_IRQ_PEND = 5'h10;
    localparam logic [ADDR_W-1:0] OFF_IRQ_EDGE = 5'h14;

    // Word index of each register (byte offset divided by four).
    typedef enum logic [2:0] {
        REG_DATA_IN  = 3'd0,
        REG_DATA_OUT = 3'd1,
        REG_DIR      = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_PEND = 3'd4,
        REG_IRQ_EDGE = 3'd5
    } reg_idx_e;

    function automatic reg_idx_e reg_idx(input logic [ADDR_W-1:0] addr);
        return reg_idx_e'(addr[4:2]);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One pin: 2-flop synchronizer, optional debounce filter (GPIO_DEBOUNCE_EN), edge detector.
module gpio_sync_edge
`ifdef GPIO_DEBOUNCE_EN
    #(parameter int DB_CYCLES = 4)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic       sync_p0;
    logic       sync_p1;
    logic       prev;
    logic [1:0] warm;
    logic       ready;

    // Edges stay masked until the synchronizer holds a real pin sample and prev is loaded from it.
    assign ready = (warm == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev    <= 1'b0;
            warm    <= 2'd0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            prev    <= ready ? filt : sync_p1;
            if (!ready) begin
                warm <= warm + 2'd1;
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          filt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt    <= '0;
        end else if (!ready) begin
            filt_q <= sync_p1;
            cnt    <= '0;
        end else if (sync_p1 != filt_q) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
                filt_q <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_p1;
`endif

    assign rise = ready & filt & ~prev;
    assign fall = ready & ~filt & prev;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO block with edge-triggered interrupts and a simple request/ack register bus.
// Optional pin debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int N_PINS    = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ack,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              gpio_irq
);

    if (N_PINS < 1 || N_PINS > 32 || DB_CYCLES < 1) begin : g_bad_param
        $error("gpio_irq_ctrl: N_PINS must be 1..32 and DB_CYCLES >= 1");
    end

    logic [N_PINS-1:0] data_out;
    logic [N_PINS-1:0] dir;
    logic [N_PINS-1:0] irq_en;
    logic [N_PINS-1:0] irq_pend;
    logic [N_PINS-1:0] irq_edge;
    logic [N_PINS-1:0] filt;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] evt;
    logic [N_PINS-1:0] w1c;
    logic [N_PINS-1:0] rd_val;
    logic              wr;
    reg_idx_e          idx;
    logic              unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        gpio_sync_edge
`ifdef GPIO_DEBOUNCE_EN
            #(.DB_CYCLES(DB_CYCLES))
`endif
            u_sync (
                .clk   (clk),
                .reset (reset),
                .pin   (gpio_in[i]),
                .filt  (filt[i]),
                .rise  (rise[i]),
                .fall  (fall[i])
            );
    end

    assign idx = reg_idx(bus_addr);
    assign wr  = bus_req & bus_we;
    assign evt = (irq_edge & rise) | (~irq_edge & fall);
    assign w1c = (wr && idx == REG_IRQ_PEND) ? bus_wdata[N_PINS-1:0] : '0;

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_DATA_IN:  rd_val = filt;
            REG_DATA_OUT: rd_val = data_out;
            REG_DIR:      rd_val = dir;
            REG_IRQ_EN:   rd_val = irq_en;
            REG_IRQ_PEND: rd_val = irq_pend;
            REG_IRQ_EDGE: rd_val = irq_edge;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            dir       <= '0;
            irq_en    <= '0;
            irq_pend  <= '0;
            irq_edge  <= '0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack <= bus_req;
            if (bus_req) begin
                bus_rdata <= DATA_W'(rd_val);
            end
            if (wr) begin
                case (idx)
                    REG_DATA_OUT: data_out <= bus_wdata[N_PINS-1:0];
                    REG_DIR:      dir      <= bus_wdata[N_PINS-1:0];
                    REG_IRQ_EN:   irq_en   <= bus_wdata[N_PINS-1:0];
                    REG_IRQ_EDGE: irq_edge <= bus_wdata[N_PINS-1:0];
                    default:      ;
                endcase
            end
            // A fresh edge wins over a W1C landing on the same edge.
            irq_pend <= (irq_pend & ~w1c) | evt;
        end
    end

    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign gpio_irq = |(irq_pend & irq_en);

endmodule
